btn_intr_port: RTL

- Input-direction IOBUS responder. It synchronizes and debounces the dev-board buttons and captures press events into a pending register.
- It raises a masked interrupt to the OTTER MCU `intr` input. The MCU reads status and pending over IOBUS, writes the mask, and clears pending bits write-1-to-clear.
- It sits in the OTTER wrapper beside the timer-counter and is the input-side counterpart of the output-port registers.

---
 rtl/btn_intr_pkg.sv | 10 +
 rtl/db_sync_bit.sv | 68 ++++++
 rtl/btn_intr_port.sv | 58 +++++
 3 files changed

// File: rtl/btn_intr_pkg.sv
// Shared IOBUS addresses and debounce state encoding for the button interrupt port.
package btn_intr_pkg;
    localparam logic [31:0] STATUS_ADDR  = 32'h1100_8010;
    localparam logic [31:0] PEND_ADDR    = 32'h1100_8014;
    localparam logic [31:0] MASK_RD_ADDR = 32'h1100_8018;
    localparam logic [31:0] MASK_WR_ADDR = 32'h1100_D010;
    localparam logic [31:0] CLR_WR_ADDR  = 32'h1100_D014;

    typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;
endpackage

// File: rtl/db_sync_bit.sv
// One button: 2-FF synchronizer, consecutive-stable-cycle debouncer and press edge detect.
module db_sync_bit
    import btn_intr_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic RST_N,
    input  logic raw,
    output logic deb,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          s_btn;
    logic          deb_q;
    logic          deb_nx;
    logic [CW-1:0] cnt, cnt_nx;
    db_state_t     state, state_nx;

    assign s_btn = sync[1];

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            sync  <= '0;
            state <= DB_STABLE;
            cnt   <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_nx;
            cnt   <= cnt_nx;
            deb   <= deb_nx;
            deb_q <= deb;
        end
    end

    // cnt holds the number of consecutive mismatching samples seen so far.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        deb_nx   = deb;
        case (state)
            DB_STABLE: begin
                if (s_btn != deb) begin
                    state_nx = DB_COUNTING;
                    cnt_nx   = CW'(1);
                end
            end
            DB_COUNTING: begin
                if (s_btn == deb) begin
                    state_nx = DB_STABLE;
                end else if (cnt == CNT_LAST) begin
                    deb_nx   = s_btn;
                    state_nx = DB_STABLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = DB_STABLE;
        endcase
    end

    always_comb rise = deb & ~deb_q;
endmodule

// File: rtl/btn_intr_port.sv
// IOBUS responder: debounced button status, W1C press-pending flags, mask and level interrupt.
module btn_intr_port
    import btn_intr_pkg::*;
#(
    parameter int N_BTNS    = 5,
    parameter int DB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic [N_BTNS-1:0] btn_in,
    input  logic [31:0]       iobus_addr,
    input  logic [31:0]       iobus_out,
    input  logic              iobus_wr,
    output logic [31:0]       iobus_rd_data,
    output logic              intr
);
    logic [N_BTNS-1:0] deb, rise, pend, mask, clr;
    logic              mask_we, clr_we;
    logic              unused_wr_bits;

    for (genvar i = 0; i < N_BTNS; i++) begin : g_btn
        db_sync_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .RST_N (RST_N),
            .raw   (btn_in[i]),
            .deb   (deb[i]),
            .rise  (rise[i])
        );
    end

    assign mask_we        = iobus_wr && (iobus_addr == MASK_WR_ADDR);
    assign clr_we         = iobus_wr && (iobus_addr == CLR_WR_ADDR);
    assign clr            = clr_we ? iobus_out[N_BTNS-1:0] : '0;
    assign unused_wr_bits = ^iobus_out[31:N_BTNS];

    // A press landing on the same edge as its clear must not be lost, so set wins.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            pend <= '0;
            mask <= '0;
            intr <= 1'b0;
        end else begin
            pend <= rise | (pend & ~clr);
            if (mask_we) mask <= iobus_out[N_BTNS-1:0];
            intr <= |(pend & mask);
        end
    end

    always_comb begin
        iobus_rd_data = '0;
        case (iobus_addr)
            STATUS_ADDR:  iobus_rd_data[N_BTNS-1:0] = deb;
            PEND_ADDR:    iobus_rd_data[N_BTNS-1:0] = pend;
            MASK_RD_ADDR: iobus_rd_data[N_BTNS-1:0] = mask;
            default:      iobus_rd_data = '0;
        endcase
    end
endmodule
